// File: rtl/qspi_mem_controller_pkg.sv
// qspi_mem_controller_pkg: shared state encoding, QSPI opcodes and nibble counts
package qspi_mem_controller_pkg;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
   localparam logic [7:0] CMD_READ = 8'hEB;
   localparam logic [7:0] CMD_WRITE = 8'h38;
   localparam int CMD_NIBBLES = 2;
   localparam int ADDR_NIBBLES = 6;
   localparam int DATA_NIBBLES = 2;
endpackage

// File: rtl/qspi_nibble_shifter.sv
// qspi_nibble_shifter: 32-bit register loaded in parallel, shifted a nibble at a time MSB-first
module qspi_nibble_shifter (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        shift,
   input  logic [3:0]  shift_in,
   output logic [3:0]  nibble_out,
   output logic [3:0]  low_nibble
);
   logic [31:0] value;
   // parallel load wins over shift; shifting pushes a nibble in at the bottom
   always_ff @(posedge clock or negedge reset)
      if (!reset) value <= 32'h0;
      else if (load) value <= load_value;
      else if (shift) value <= {value[27:0], shift_in};
   assign nibble_out = value[31:28];
   assign low_nibble = value[3:0];
endmodule

// File: rtl/qspi_mem_controller.sv
// qspi_mem_controller: single-byte CPU requests to quad-SPI flash / RAM A
module qspi_mem_controller
   import qspi_mem_controller_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_BUS_WIDTH = 8,
   parameter int DUMMY_CYCLES   = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic                      req_target,
   input  logic [ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
   output logic                      resp_valid,
   output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
   output logic                      resp_err,
   input  logic [3:0]                spi_data_in,
   output logic [3:0]                spi_data_out,
   output logic [3:0]                spi_data_oe,
   output logic                      spi_clk_out,
   output logic                      spi_flash_select,
   output logic                      spi_ram_a_select
);
   state_t state, state_next;
   logic phase, last, accept, active, drive;
   logic [7:0] cnt, limit;
   logic write_q, target_q, err_q;
   logic [DATA_BUS_WIDTH-1:0] wdata_q;
   logic [3:0] nibble_out, low_nibble, shift_in;

   assign accept = req_valid && req_ready;
   assign active = state inside {CMD, ADDR, DUMMY, DATA};
   assign limit = state == CMD ? 8'(CMD_NIBBLES) :
                  state == ADDR ? 8'(ADDR_NIBBLES) :
                  state == DUMMY ? 8'(DUMMY_CYCLES) : 8'(DATA_NIBBLES);
   assign last = phase && cnt == limit - 8'd1;
   assign drive = state == CMD || state == ADDR || (state == DATA && write_q);
   // write data rides in behind the command so it reaches the top after the address
   assign shift_in = state == CMD ? (cnt == 8'd0 ? wdata_q[7:4] : wdata_q[3:0]) :
                     state == DATA ? spi_data_in : 4'h0;

   // state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_next;

   // next state: flash writes are rejected straight to DONE
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (req_write && !req_target) ? DONE : CMD;
         CMD:     if (last) state_next = ADDR;
         ADDR:    if (last) state_next = (write_q || DUMMY_CYCLES == 0) ? DATA : DUMMY;
         DUMMY:   if (last) state_next = DATA;
         DATA:    if (last) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // outputs: SPI clock high on the second cycle of each nibble slot
   always_comb begin
      spi_clk_out = active && phase;
      spi_flash_select = !(active && !target_q);
      spi_ram_a_select = !(active && target_q);
      spi_data_oe = drive ? 4'hF : 4'h0;
      spi_data_out = drive ? nibble_out : 4'h0;
      resp_valid = state == DONE;
      resp_err = state == DONE && err_q;
   end

   // nibble slot phase and per-state nibble counter
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         phase <= 1'b0;
         cnt <= 8'd0;
      end else begin
         phase <= active && !phase;
         cnt <= state_next != state ? 8'd0 : cnt + 8'(phase);
      end

   // latch the accepted request
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         write_q <= 1'b0;
         target_q <= 1'b0;
         err_q <= 1'b0;
         wdata_q <= '0;
      end else if (accept) begin
         write_q <= req_write;
         target_q <= req_target;
         err_q <= req_write && !req_target;
         wdata_q <= req_wdata;
      end

   // ready is registered: it rises one cycle after entering IDLE and drops on accept
   always_ff @(posedge clock or negedge reset)
      if (!reset) req_ready <= 1'b0;
      else req_ready <= state == IDLE && !accept;

   // read byte captured on the final sampling edge so it is valid alongside resp_valid
   always_ff @(posedge clock or negedge reset)
      if (!reset) resp_rdata <= '0;
      else if (state == DATA && last && !write_q) resp_rdata <= DATA_BUS_WIDTH'({low_nibble, spi_data_in});

   qspi_nibble_shifter u_shifter (
      .clock      (clock),
      .reset      (reset),
      .load       (accept),
      .load_value ({req_write ? CMD_WRITE : CMD_READ, 24'(req_addr)}),
      .shift      (active && phase),
      .shift_in   (shift_in),
      .nibble_out (nibble_out),
      .low_nibble (low_nibble)
   );
endmodule
